// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch unit (master)
// and a variable-latency instruction memory (slave).
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imemReq;
  logic [XLEN-1:0] imemAddr;
  logic            imemAck;
  logic [XLEN-1:0] imemRdata;

  modport master (output imemReq, output imemAddr, input imemAck, input imemRdata);
  modport slave  (input imemReq, input imemAddr, output imemAck, output imemRdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns pc and the instruction register, runs one request/ack
// transaction per IRWrite pulse with a bounded wait and sticky error flags.
//
// state | meaning
// IDLE  | no fetch outstanding; IRWrite starts one at the current pc
// WAIT  | request outstanding; leaves on ack or after TIMEOUT_CYCLES edges
module instr_fetch_unit #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int              TIMEOUT_CYCLES = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                IRWrite,
  input  logic                PCWrite,
  input  logic [XLEN-1:0]     pcNext,
  instr_fetch_unit_if.master  imem,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     instr,
  output logic [6:0]          opCode,
  output logic                instrValid,
  output logic                fetchBusy,
  output logic                busErr,
  output logic                misalignErr
);
  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] addr;

  // Request is derived from state so it drops asynchronously with reset.
  assign imem.imemReq  = (state == WAIT);
  assign imem.imemAddr = addr;
  assign fetchBusy     = (state == WAIT);
  assign opCode        = instr[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr       <= RESET_PC;
      instr      <= NOP;
      instrValid <= 1'b0;
      busErr     <= 1'b0;
    end else if (state == IDLE) begin
      if (IRWrite) begin
        addr       <= pc;
        instrValid <= 1'b0;
        cnt        <= '0;
        state      <= WAIT;
      end
    end else begin
      if (imem.imemAck) begin
        instr      <= imem.imemRdata;
        instrValid <= 1'b1;
        state      <= IDLE;
      end else if (cnt == CNT_LAST) begin
        instr      <= NOP;
        instrValid <= 1'b1;
        busErr     <= 1'b1;
        state      <= IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      misalignErr <= 1'b0;
    end else if (PCWrite) begin
      pc <= {pcNext[XLEN-1:2], 2'b00};
      if (pcNext[1:0] != 2'b00) misalignErr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a transaction-level model.
module tb_instr_fetch_unit;
  localparam int          TO  = 15;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IRWrite = 1'b0, PCWrite = 1'b0;
  logic [31:0] pcNext = '0;
  logic [31:0] pc, instr;
  logic [6:0]  opCode;
  logic        instrValid, fetchBusy, busErr, misalignErr;
  bit          chk_en = 1'b0;
  int          checks = 0, errors = 0;

  instr_fetch_unit_if #(.XLEN(32)) imem ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RPC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .IRWrite(IRWrite), .PCWrite(PCWrite), .pcNext(pcNext),
    .imem(imem), .pc(pc), .instr(instr), .opCode(opCode), .instrValid(instrValid),
    .fetchBusy(fetchBusy), .busErr(busErr), .misalignErr(misalignErr));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Transaction-level model: a fetch is outstanding for a number of edges
  // counted from its request edge and ends at the first ack or at edge TO.
  logic [31:0] m_pc, m_addr, m_instr;
  bit          m_busy, m_valid, m_bus, m_mis;
  int          m_since;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RPC; m_addr = RPC; m_instr = NOP;
      m_busy = 0; m_valid = 0; m_bus = 0; m_mis = 0; m_since = 0;
    end else begin
      if (m_busy) begin
        m_since++;
        if (imem.imemAck) begin
          m_instr = imem.imemRdata; m_valid = 1; m_busy = 0;
        end else if (m_since == TO) begin
          m_instr = NOP; m_valid = 1; m_bus = 1; m_busy = 0;
        end
      end else if (IRWrite) begin
        m_addr = m_pc; m_busy = 1; m_valid = 0; m_since = 0;
      end
      if (PCWrite) begin
        m_pc  = pcNext & 32'hFFFF_FFFC;
        m_mis = m_mis | (pcNext[1:0] != 2'b00);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imemReq", {31'd0, imem.imemReq}, {31'd0, m_busy});
      chk("fetchBusy", {31'd0, fetchBusy}, {31'd0, m_busy});
      if (m_busy) chk("imemAddr", imem.imemAddr, m_addr);
      chk("pc", pc, m_pc);
      chk("instr", instr, m_instr);
      chk("opCode", {25'd0, opCode}, {25'd0, m_instr[6:0]});
      chk("instrValid", {31'd0, instrValid}, {31'd0, m_valid});
      chk("busErr", {31'd0, busErr}, {31'd0, m_bus});
      chk("misalignErr", {31'd0, misalignErr}, {31'd0, m_mis});
    end
  end

  // Called at a negedge: apply inputs, let one rising edge pass, return at next negedge.
  task automatic step(input bit irw, input bit pcw, input logic [31:0] pcn,
                      input bit ack, input logic [31:0] rd);
    IRWrite = irw; PCWrite = pcw; pcNext = pcn;
    imem.imemAck = ack; imem.imemRdata = rd;
    @(posedge clk);
    @(negedge clk);
    IRWrite = 0; PCWrite = 0; imem.imemAck = 0;
  endtask

  int hi;

  initial begin
    imem.imemAck = 0; imem.imemRdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1; chk_en = 1;
    @(negedge clk);
    chk("rst_pc", pc, RPC);
    chk("rst_instr", instr, NOP);
    chk("rst_req", {31'd0, imem.imemReq}, 32'd0);

    // Ack three edges after the request edge.
    step(1, 0, 0, 0, 0);
    chk("t1_addr0", imem.imemAddr, 32'h0);
    chk("t1_req", {31'd0, imem.imemReq}, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("t1_addr1", imem.imemAddr, 32'h0);
    step(0, 0, 0, 0, 0);
    chk("t1_addr2", imem.imemAddr, 32'h0);
    step(0, 0, 0, 1, 32'h0020_8133);
    chk("t1_instr", instr, 32'h0020_8133);
    chk("t1_opcode", {25'd0, opCode}, 32'h33);
    chk("t1_valid", {31'd0, instrValid}, 32'd1);
    chk("t1_busy", {31'd0, fetchBusy}, 32'd0);

    // Ack in the first WAIT cycle.
    step(1, 0, 0, 0, 0);
    hi = imem.imemReq ? 1 : 0;
    step(0, 0, 0, 1, 32'h1234_5677);
    chk("t2_req_cycles", hi, 1);
    chk("t2_instr", instr, 32'h1234_5677);

    // No ack: timeout.
    step(1, 0, 0, 0, 0);
    hi = 0;
    for (int i = 0; i < 40 && imem.imemReq; i++) begin
      hi++;
      step(0, 0, 0, 0, 0);
    end
    chk("t3_req_cycles", hi, TO);
    chk("t3_instr", instr, NOP);
    chk("t3_buserr", {31'd0, busErr}, 32'd1);
    chk("t3_valid", {31'd0, instrValid}, 32'd1);
    step(0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t3_late_ack", instr, NOP);

    // Misaligned PCWrite and a second IRWrite during WAIT.
    step(1, 0, 0, 0, 0);
    step(1, 1, 32'h0000_0006, 0, 0);
    chk("t4_addr", imem.imemAddr, 32'h0);
    chk("t4_pc", pc, 32'h4);
    chk("t4_mis", {31'd0, misalignErr}, 32'd1);
    step(0, 0, 0, 1, 32'h0000_0093);
    chk("t4_idle", {31'd0, imem.imemReq}, 32'd0);

    // Simultaneous PCWrite and IRWrite in IDLE with pc=4.
    step(1, 1, 32'h0000_0008, 0, 0);
    chk("t5_addr", imem.imemAddr, 32'h4);
    chk("t5_pc", pc, 32'h8);

    // Reset mid-WAIT drops the request asynchronously.
    #2 rst_n = 0;
    #1;
    chk("t6_req", {31'd0, imem.imemReq}, 32'd0);
    chk("t6_busy", {31'd0, fetchBusy}, 32'd0);
    chk("t6_pc", pc, RPC);
    chk("t6_flags", {29'd0, busErr, misalignErr, instrValid}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 0, 1, 32'hCAFE_F00D);
    chk("t6_ack_ignored", instr, NOP);
    chk("t6_valid", {31'd0, instrValid}, 32'd0);

    // Randomized traffic; every third segment starves acks to force timeouts.
    for (int seg = 0; seg < 30; seg++) begin
      for (int c = 0; c < 80; c++) begin
        step($urandom_range(0, 3) == 0,
             $urandom_range(0, 7) == 0,
             {24'd0, 8'($urandom_range(0, 255))},
             (seg % 3 != 2) && ($urandom_range(0, 2) == 0),
             $urandom);
      end
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
